// File: rtl/bp_be_mem_replay_queue_if.sv
// Dispatch-side and memory-pipe-side handshake bundle for the memory replay queue.
// slave is the replay queue's view; master is the dispatch/pipe environment's view.
interface bp_be_mem_replay_queue_if #(
    parameter int pkt_width_p = 512
);
    logic                   issue_v_i;
    logic [pkt_width_p-1:0] issue_pkt_i;
    logic                   issue_ready_o;
    logic                   mem_v_o;
    logic [pkt_width_p-1:0] mem_pkt_o;
    logic                   mem_ready_i;

    modport slave (
        input  issue_v_i, issue_pkt_i, mem_ready_i,
        output issue_ready_o, mem_v_o, mem_pkt_o
    );

    modport master (
        output issue_v_i, issue_pkt_i, mem_ready_i,
        input  issue_ready_o, mem_v_o, mem_pkt_o
    );
endinterface

// File: rtl/bp_be_mem_replay_queue.sv
// Memory replay buffer: passes reservations to the mem pipe, tracks them through mem1/mem2,
// captures D$/D-TLB misses and re-issues them in program order.
module bp_be_mem_replay_queue #(
    parameter int pkt_width_p = 512,
    parameter int cnt_width_p = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         flush_i,
    bp_be_mem_replay_queue_if.slave      bus,
    input  logic                         cache_miss_v_i,
    input  logic                         tlb_miss_v_i,
    input  logic                         fault_v_i,
    output logic                         replay_busy_o,
    output logic [cnt_width_p-1:0]       replay_cnt_o
);

    typedef enum logic [1:0] {
        e_idle,
        e_wait,
        e_replay
    } state_e;

    state_e                  state_r;
    logic                    v1_r, v2_r;
    logic [pkt_width_p-1:0]  pkt1_r, pkt2_r;
    logic [pkt_width_p-1:0]  q_r [2];
    logic [1:0]              q_cnt_r;
    logic [cnt_width_p-1:0]  cnt_r;

    logic                    miss, kill, block, fire;
    logic                    mem_v;
    logic                    issue_ready;
    logic [pkt_width_p-1:0]  mem_pkt;

    assign miss  = v2_r & (cache_miss_v_i | tlb_miss_v_i) & ~fault_v_i & ~flush_i;
    assign kill  = v2_r & fault_v_i & ~flush_i;
    assign block = miss | kill | flush_i;

    // Outputs are combinational so IDLE is a zero-latency pass-through; reset gates them directly.
    always_comb begin
        mem_v       = 1'b0;
        issue_ready = 1'b0;
        mem_pkt     = bus.issue_pkt_i;
        unique case (state_r)
            e_idle: begin
                mem_v       = bus.issue_v_i & ~block;
                issue_ready = bus.mem_ready_i & ~block;
            end
            e_replay: begin
                mem_v   = ~block;
                mem_pkt = q_r[0];
            end
            default: ;
        endcase
        if (!reset_n_i) begin
            mem_v       = 1'b0;
            issue_ready = 1'b0;
            mem_pkt     = '0;
        end
    end

    assign fire              = mem_v & bus.mem_ready_i;
    assign bus.mem_v_o       = mem_v;
    assign bus.mem_pkt_o     = mem_pkt;
    assign bus.issue_ready_o = issue_ready;
    assign replay_busy_o     = (state_r != e_idle);
    assign replay_cnt_o      = cnt_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
            v1_r    <= 1'b0;
            v2_r    <= 1'b0;
            pkt1_r  <= '0;
            pkt2_r  <= '0;
            q_r[0]  <= '0;
            q_r[1]  <= '0;
            q_cnt_r <= '0;
            cnt_r   <= '0;
        end else begin
            pkt1_r <= mem_pkt;
            pkt2_r <= pkt1_r;
            v1_r   <= fire;
            v2_r   <= v1_r & ~block;
            if (flush_i) begin
                state_r <= e_idle;
                q_cnt_r <= '0;
            end else if (miss) begin
                // Missing access goes first, then its younger in-flight access, then the old head.
                q_r[0]  <= pkt2_r;
                q_r[1]  <= v1_r ? pkt1_r : q_r[0];
                q_cnt_r <= (v1_r || (q_cnt_r != 2'd0)) ? 2'd2 : 2'd1;
                state_r <= e_wait;
                cnt_r   <= (&cnt_r) ? cnt_r : cnt_r + 1'b1;
            end else begin
                unique case (state_r)
                    e_wait: begin
                        if (bus.mem_ready_i) state_r <= e_replay;
                    end
                    e_replay: begin
                        if (fire) begin
                            q_r[0]  <= q_r[1];
                            q_cnt_r <= q_cnt_r - 2'd1;
                            if (q_cnt_r == 2'd1) state_r <= e_idle;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
